// File: rtl/btn_event_pkg.sv
// rtl/btn_event_pkg.sv - shared types and sizing helpers for the button event front end
package btn_event_pkg;

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} btn_state_t;

  function automatic int ms_div(input int clk_hz);
    return clk_hz / 1000;
  endfunction

  // Width able to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_event_chan.sv
// rtl/btn_event_chan.sv - one button channel: 2-FF sync, debounce, press/hold FSM
// Auto-repeat strobes exist only when BTN_EVENT_AUTOREPEAT_EN is defined.
module btn_event_chan
  import btn_event_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 800,
  parameter int REPEAT_MS   = 150,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic ms_stb,
  input  logic btn_raw,
  output logic level,
  output logic press,
  output logic rel_tick,
  output logic long_tick,
  output logic rep_tick
);

  localparam int   DB_W     = cnt_w(DEBOUNCE_MS);
  localparam int   HOLD_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
  localparam int   HOLD_W   = cnt_w(HOLD_MAX);
  localparam logic REL_RAW  = (ACTIVE_LOW != 0);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_MS - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_MS - 1);
`ifdef BTN_EVENT_AUTOREPEAT_EN
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_MS - 1);
`endif

  logic            sync_q0, sync_q1;
  logic            stable_q;
  logic [DB_W-1:0] db_cnt;
  logic            sync_p;

  // Normalised so that 1 always means pressed from here on.
  assign sync_p = sync_q1 ^ REL_RAW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q0  <= REL_RAW;
      sync_q1  <= REL_RAW;
      stable_q <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync_q0 <= btn_raw;
      sync_q1 <= sync_q0;
      if (sync_p == stable_q) begin
        db_cnt <= '0;
      end else if (ms_stb) begin
        if (db_cnt >= DB_LAST) begin
          stable_q <= ~stable_q;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end
    end
  end

  btn_state_t        state_q, state_n;
  logic [HOLD_W-1:0] hold_q, hold_n;
  logic              press_n, rel_n, long_n;
  logic              press_q, rel_q, long_q;
`ifdef BTN_EVENT_AUTOREPEAT_EN
  logic              rep_n, rep_q;
`endif

  always_comb begin
    state_n = state_q;
    hold_n  = hold_q;
    press_n = 1'b0;
    rel_n   = 1'b0;
    long_n  = 1'b0;
`ifdef BTN_EVENT_AUTOREPEAT_EN
    rep_n   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (stable_q) begin
          state_n = PRESSED;
          press_n = 1'b1;
          hold_n  = '0;
        end
      end
      PRESSED: begin
        if (!stable_q) begin
          state_n = IDLE;
          rel_n   = 1'b1;
          hold_n  = '0;
        end else if (ms_stb) begin
          if (hold_q >= LONG_LAST) begin
            state_n = HELD;
            long_n  = 1'b1;
            hold_n  = '0;
          end else begin
            hold_n = hold_q + 1'b1;
          end
        end
      end
      HELD: begin
        // Release wins over a repeat falling due in the same cycle.
        if (!stable_q) begin
          state_n = IDLE;
          rel_n   = 1'b1;
          hold_n  = '0;
        end
`ifdef BTN_EVENT_AUTOREPEAT_EN
        else if (ms_stb) begin
          if (hold_q >= REP_LAST) begin
            rep_n  = 1'b1;
            hold_n = '0;
          end else begin
            hold_n = hold_q + 1'b1;
          end
        end
`endif
      end
      default: begin
        state_n = IDLE;
        hold_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      hold_q  <= hold_n;
      press_q <= press_n;
      rel_q   <= rel_n;
      long_q  <= long_n;
    end
  end

`ifdef BTN_EVENT_AUTOREPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rep_q <= 1'b0;
    else     rep_q <= rep_n;
  end
  assign rep_tick = rep_q;
`else
  assign rep_tick = 1'b0;
`endif

  assign level     = (state_q != IDLE);
  assign press     = press_q;
  assign rel_tick  = rel_q;
  assign long_tick = long_q;

endmodule

// File: rtl/btn_event_ctrl.sv
// rtl/btn_event_ctrl.sv - N-channel button front end with shared ms prescaler
// Optional auto-repeat enabled by defining BTN_EVENT_AUTOREPEAT_EN.
module btn_event_ctrl
  import btn_event_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int CLK_HZ      = 27_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 800,
  parameter int REPEAT_MS   = 150,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] rel_tick,
  output logic [N_CH-1:0] long_tick,
  output logic [N_CH-1:0] rep_tick
);

  localparam int DIV  = ms_div(CLK_HZ);
  localparam int PS_W = cnt_w(DIV - 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

  logic [PS_W-1:0] ps_cnt;
  logic            ms_stb;

  assign ms_stb = (ps_cnt == PS_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ps_cnt <= '0;
    else if (ms_stb) ps_cnt <= '0;
    else             ps_cnt <= ps_cnt + 1'b1;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    btn_event_chan #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .LONG_MS     (LONG_MS),
      .REPEAT_MS   (REPEAT_MS),
      .ACTIVE_LOW  (ACTIVE_LOW)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .ms_stb    (ms_stb),
      .btn_raw   (btn_raw[i]),
      .level     (level[i]),
      .press     (press[i]),
      .rel_tick  (rel_tick[i]),
      .long_tick (long_tick[i]),
      .rep_tick  (rep_tick[i])
    );
  end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// tb/tb_btn_event_ctrl.sv - directed self-checking bench for btn_event_ctrl
// Repeat expectations follow BTN_EVENT_AUTOREPEAT_EN.
module tb_btn_event_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn_raw;
  logic [1:0] level, press, rel_tick, long_tick, rep_tick;

  btn_event_ctrl #(
    .N_CH        (2),
    .CLK_HZ      (1_000_000),
    .DEBOUNCE_MS (1),
    .LONG_MS     (5),
    .REPEAT_MS   (2),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .level     (level),
    .press     (press),
    .rel_tick  (rel_tick),
    .long_tick (long_tick),
    .rep_tick  (rep_tick)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int   press_cnt[2], rel_cnt[2], long_cnt[2], rep_cnt[2];
  int   press_at[2], long_at[2], rep_first[2];
  logic lvl_seen[2];
  logic clr = 1'b0;

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (clr) begin
        press_cnt[c] = 0; rel_cnt[c] = 0; long_cnt[c] = 0; rep_cnt[c] = 0;
        press_at[c] = 0; long_at[c] = 0; rep_first[c] = 0; lvl_seen[c] = 1'b0;
      end else if (!rst) begin
        if (press[c])     begin press_cnt[c]++; press_at[c] = cyc; end
        if (rel_tick[c])  rel_cnt[c]++;
        if (long_tick[c]) begin long_cnt[c]++; long_at[c] = cyc; end
        if (rep_tick[c])  begin
          if (rep_cnt[c] == 0) rep_first[c] = cyc;
          rep_cnt[c]++;
        end
        if (level[c]) lvl_seen[c] = 1'b1;
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Returns nominal when d lies in [lo,hi], otherwise d itself so the FAIL line shows it.
  function automatic int win(input int d, input int lo, input int hi, input int nominal);
    return (d >= lo && d <= hi) ? nominal : d;
  endfunction

  task automatic clear_mon();
    @(posedge clk); clr = 1'b1;
    @(posedge clk); clr = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    for (int n = 0; n < 1000 && (cyc % 1000) != ph; n++) @(negedge clk);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_press(input int ch, input int budget, input string tag);
    int n = 0;
    while (press_cnt[ch] == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, (press_cnt[ch] > 0) ? 1 : 0, 1);
  endtask

  task automatic bounce(input int ch, input logic final_lvl);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      btn_raw[ch] = (i % 2 == 0) ? 1'b0 : 1'b1;
    end
    @(negedge clk);
    btn_raw[ch] = final_lvl;
  endtask

  int p, last_edge;

  initial begin
    btn_raw = 2'b11;
    rst     = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_level",     int'(level),     0);
    check("rst_press",     int'(press),     0);
    check("rst_strobes",   int'(rel_tick | long_tick | rep_tick), 0);
    rst = 1'b0;
    clear_mon();

    // 1: bouncing press on ch0
    wait_phase(300);
    bounce(0, 1'b0);
    last_edge = cyc;
    wait_press(0, 2100, "t1_press_seen");
    check("t1_press_latency", win(press_at[0] - last_edge, 0, 2003, 1), 1);
    p = press_at[0];

    // 2: held for 9.5 ms
    wait_until(p + 9500);
    check("t1_press_once",    press_cnt[0], 1);
    check("t1_level0",        int'(level[0]), 1);
    check("t1_ch1_quiet",     press_cnt[1] + rel_cnt[1] + long_cnt[1] + rep_cnt[1], 0);
    check("t2_long_once",     long_cnt[0], 1);
    check("t2_long_delay",    win(long_at[0] - p, 4998, 5001, 5000), 5000);
    check("t2_no_rel",        rel_cnt[0], 0);
`ifdef BTN_EVENT_AUTOREPEAT_EN
    check("t2_rep_count",     rep_cnt[0], 2);
    check("t2_rep_first",     win(rep_first[0] - long_at[0], 1999, 2001, 2000), 2000);
`else
    check("t2_rep_none",      rep_cnt[0], 0);
`endif
    btn_raw[0] = 1'b1;
    repeat (2000) @(negedge clk);
    check("t2_rel_from_held", rel_cnt[0], 1);
    check("t2_long_still1",   long_cnt[0], 1);

    // 3: short press, bouncing release after 3 ms
    clear_mon();
    wait_phase(300);
    btn_raw[0] = 1'b0;
    wait_press(0, 2100, "t3_press_seen");
    p = press_at[0];
    wait_until(p + 3000);
    bounce(0, 1'b1);
    repeat (2500) @(negedge clk);
    check("t3_rel_once",      rel_cnt[0], 1);
    check("t3_no_long",       long_cnt[0], 0);
    check("t3_press_once",    press_cnt[0], 1);
    check("t3_level0",        int'(level[0]), 0);

    // 4: 300-cycle glitch on ch1 between ms strobes
    clear_mon();
    wait_phase(100);
    btn_raw[1] = 1'b0;
    repeat (300) @(negedge clk);
    btn_raw[1] = 1'b1;
    repeat (2000) @(negedge clk);
    check("t4_ch1_no_strobe", press_cnt[1] + rel_cnt[1] + long_cnt[1], 0);
    check("t4_ch1_level",     int'(lvl_seen[1]), 0);

    // 5: both channels together
    clear_mon();
    wait_phase(300);
    btn_raw = 2'b00;
    wait_press(0, 2100, "t5_press0_seen");
    wait_press(1, 10,   "t5_press1_seen");
    check("t5_same_cycle",    press_at[1] - press_at[0], 0);
    check("t5_level_both",    int'(level), 3);

    // 6: reset while HELD, button kept down
    p = press_at[0];
    wait_until(p + 6000);
    check("t6_held_long",     long_cnt[0], 1);
    rst = 1'b1;
    #1;
    check("t6_rst_level",     int'(level), 0);
    check("t6_rst_outs",      int'(press | rel_tick | long_tick | rep_tick), 0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    clear_mon();
    wait_press(0, 1100, "t6_repress_seen");
    check("t6_repress_lat",   win(press_at[0], 0, 1003, 1), 1);
    p = press_at[0];
    wait_until(p + 5500);
    check("t6_long_once",     long_cnt[0], 1);
    check("t6_long_delay",    win(long_at[0] - p, 4998, 5001, 5000), 5000);
    check("t6_no_rel",        rel_cnt[0] + rel_cnt[1], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
